pid_param_uart_rx: RTL and testbench

Serial command receiver that lets a host retune the wall-follower PID loop at run time. It is the inbound counterpart of the telemetry UART transmitter. It deserialises 8N1 bytes from `serial_rx` and parses fixed 5-byte command frames. Checksum-valid frames update the k_p/k_i/k_d gain registers or the distance setpoint that feed `pid_controller`.

---
 rtl/pid_param_uart_rx.sv | 241 ++++++++++++++++++++++++
 tb/tb_pid_param_uart_rx.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_param_uart_rx.sv
// UART command receiver: deserialises 8N1 bytes and parses A5/CMD/HI/LO/CHK frames
// that retune the PID gains and the distance setpoint at run time.
module pid_param_uart_rx #(
  parameter int CLKS_PER_BIT  = 1085,
  parameter int PID_INT_WIDTH = 16,
  parameter int SP_WIDTH      = 7,
  parameter int INIT_KP       = 500,
  parameter int INIT_KI       = 0,
  parameter int INIT_KD       = 0,
  parameter int INIT_SP       = 30,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     serial_rx,
  output logic [PID_INT_WIDTH-1:0] k_p,
  output logic [PID_INT_WIDTH-1:0] k_i,
  output logic [PID_INT_WIDTH-1:0] k_d,
  output logic [SP_WIDTH-1:0]      setpoint,
  output logic                     param_valid,
  output logic [1:0]               param_sel,
  output logic                     rx_byte_valid,
  output logic [7:0]               rx_byte,
  output logic                     err_pulse,
  output logic [7:0]               err_count,
  output logic [1:0]               dbg_rx_state,
  output logic [2:0]               dbg_parse_state
);
  localparam int CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int HALF_LAST = CLKS_PER_BIT / 2 - 1;
  localparam int TMO_LIMIT = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
  localparam int TMO_W     = $clog2(TMO_LIMIT + 1);
  localparam logic [15:0] SP_MAX = 16'((1 << SP_WIDTH) - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {P_SYNC, P_CMD, P_HI, P_LO, P_CHK} parse_state_t;

  logic rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t rx_state_q, rx_state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic byte_done, frame_err;

  parse_state_t parse_q, parse_d;
  logic [7:0] cmd_q, cmd_d, hi_q, hi_d, lo_q, lo_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic parse_err, tmo_err;
  logic [7:0] rx_byte_q, err_cnt_q, err_cnt_d;
  logic rx_valid_q, err_q, pvalid_q, pvalid_d;
  logic [PID_INT_WIDTH-1:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic [SP_WIDTH-1:0] sp_q, sp_d;
  logic [1:0] sel_q, sel_d;

  // Line synchroniser; rx_prev_q gives the previous synchronised level for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= serial_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_done  = 1'b0;
    frame_err  = 1'b0;
    if (!en) begin
      rx_state_d = R_IDLE;
      bit_cnt_d  = '0;
      bit_idx_d  = '0;
    end else begin
      case (rx_state_q)
        R_IDLE: begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          if (rx_prev_q && !rx_sync_q) rx_state_d = R_START;
        end
        R_START: begin
          if (bit_cnt_q == CNT_W'(HALF_LAST)) begin
            bit_cnt_d  = '0;
            rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
          end else bit_cnt_d = bit_cnt_q + 1'b1;
        end
        R_DATA: begin
          if (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
            bit_cnt_d = '0;
            shift_d   = {rx_sync_q, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) rx_state_d = R_STOP;
          end else bit_cnt_d = bit_cnt_q + 1'b1;
        end
        R_STOP: begin
          // Return to IDLE at the mid-stop sample so a back-to-back start bit is caught.
          if (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
            bit_cnt_d  = '0;
            rx_state_d = R_IDLE;
            if (rx_sync_q) byte_done = 1'b1;
            else frame_err = 1'b1;
          end else bit_cnt_d = bit_cnt_q + 1'b1;
        end
        default: rx_state_d = R_IDLE;
      endcase
    end
  end

  // rx_byte_valid, param_valid and err_pulse are single-cycle strobes with no ready:
  // a consumer must sample the paired data (rx_byte, param_sel, registers) in that cycle.
  always_comb begin
    parse_d   = parse_q;
    cmd_d     = cmd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    tmo_d     = tmo_q;
    kp_d      = kp_q;
    ki_d      = ki_q;
    kd_d      = kd_q;
    sp_d      = sp_q;
    sel_d     = sel_q;
    pvalid_d  = 1'b0;
    parse_err = 1'b0;
    tmo_err   = 1'b0;
    err_cnt_d = (err_q && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    if (!en) begin
      parse_d = P_SYNC;
      tmo_d   = '0;
    end else begin
      // A byte arriving on the expiry cycle clears the counter first, so it wins.
      if (parse_q == P_SYNC || rx_valid_q) tmo_d = '0;
      else if (tmo_q == TMO_W'(TMO_LIMIT - 1)) begin
        tmo_d   = '0;
        tmo_err = 1'b1;
        parse_d = P_SYNC;
      end else tmo_d = tmo_q + 1'b1;
      if (rx_valid_q) begin
        case (parse_q)
          P_SYNC: if (rx_byte_q == 8'hA5) parse_d = P_CMD;
          P_CMD: begin
            if (rx_byte_q >= 8'd1 && rx_byte_q <= 8'd4) begin
              cmd_d   = rx_byte_q;
              parse_d = P_HI;
            end else begin
              parse_err = 1'b1;
              parse_d   = P_SYNC;
            end
          end
          P_HI: begin
            hi_d    = rx_byte_q;
            parse_d = P_LO;
          end
          P_LO: begin
            lo_d    = rx_byte_q;
            parse_d = P_CHK;
          end
          P_CHK: begin
            parse_d = P_SYNC;
            if (rx_byte_q != (cmd_q ^ hi_q ^ lo_q)) parse_err = 1'b1;
            else if (cmd_q == 8'd4 && {hi_q, lo_q} > SP_MAX) parse_err = 1'b1;
            else begin
              pvalid_d = 1'b1;
              sel_d    = cmd_q[1:0] - 2'd1;
              case (cmd_q[2:0])
                3'd1:    kp_d = PID_INT_WIDTH'({hi_q, lo_q});
                3'd2:    ki_d = PID_INT_WIDTH'({hi_q, lo_q});
                3'd3:    kd_d = PID_INT_WIDTH'({hi_q, lo_q});
                default: sp_d = lo_q[SP_WIDTH-1:0];
              endcase
            end
          end
          default: parse_d = P_SYNC;
        endcase
      end
      if (frame_err) parse_d = P_SYNC;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= R_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parse_q    <= P_SYNC;
      cmd_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      tmo_q      <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      pvalid_q   <= 1'b0;
      sel_q      <= '0;
      kp_q       <= PID_INT_WIDTH'(INIT_KP);
      ki_q       <= PID_INT_WIDTH'(INIT_KI);
      kd_q       <= PID_INT_WIDTH'(INIT_KD);
      sp_q       <= SP_WIDTH'(INIT_SP);
    end else begin
      rx_state_q <= rx_state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parse_q    <= parse_d;
      cmd_q      <= cmd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      tmo_q      <= tmo_d;
      rx_valid_q <= byte_done;
      if (byte_done) rx_byte_q <= shift_q;
      err_q      <= frame_err | parse_err | tmo_err;
      err_cnt_q  <= err_cnt_d;
      pvalid_q   <= pvalid_d;
      sel_q      <= sel_d;
      kp_q       <= kp_d;
      ki_q       <= ki_d;
      kd_q       <= kd_d;
      sp_q       <= sp_d;
    end
  end

  assign k_p             = kp_q;
  assign k_i             = ki_q;
  assign k_d             = kd_q;
  assign setpoint        = sp_q;
  assign param_valid     = pvalid_q;
  assign param_sel       = sel_q;
  assign rx_byte_valid   = rx_valid_q;
  assign rx_byte         = rx_byte_q;
  assign err_pulse       = err_q;
  assign err_count       = err_cnt_q;
  assign dbg_rx_state    = rx_state_q;
  assign dbg_parse_state = parse_q;
endmodule

// File: tb/tb_pid_param_uart_rx.sv
// Directed bench for pid_param_uart_rx: a frame-level model predicts bytes, updates and
// errors; a per-cycle compare process checks the DUT against it.
module tb_pid_param_uart_rx;
  localparam int CPB   = 8;
  localparam int LIMIT = 4 * 10 * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;
  logic serial_rx = 1'b1;
  logic [15:0] k_p, k_i, k_d;
  logic [6:0] setpoint;
  logic param_valid, rx_byte_valid, err_pulse;
  logic [1:0] param_sel, dbg_rx_state;
  logic [2:0] dbg_parse_state;
  logic [7:0] rx_byte, err_count;

  pid_param_uart_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BYTES(4)) dut (
    .clk(clk), .reset(reset), .en(en), .serial_rx(serial_rx),
    .k_p(k_p), .k_i(k_i), .k_d(k_d), .setpoint(setpoint),
    .param_valid(param_valid), .param_sel(param_sel),
    .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte),
    .err_pulse(err_pulse), .err_count(err_count),
    .dbg_rx_state(dbg_rx_state), .dbg_parse_state(dbg_parse_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, v, lo, hi, cyc);
    end
  endtask

  // model state and scoreboard queues
  logic [15:0] m_kp, m_ki, m_kd;
  logic [6:0]  m_sp;
  logic [1:0]  m_sel;
  int          m_err_cnt;
  bit          bump_next;
  int          last_valid_cyc;
  logic [7:0]  fb[$];
  logic [7:0]  exp_q[$];
  int          exp_t_q[$];
  logic [1:0]  upd_sel_q[$];
  logic [15:0] upd_val_q[$];
  int          err_kind_q[$];  // 0 parser, 1 framing, 2 timeout
  int          err_t_q[$];

  function automatic void model_reset();
    m_kp = 16'd500; m_ki = 16'd0; m_kd = 16'd0; m_sp = 7'd30; m_sel = 2'd0;
    m_err_cnt = 0; bump_next = 1'b0; last_valid_cyc = 0;
    fb.delete(); exp_q.delete(); exp_t_q.delete(); upd_sel_q.delete();
    upd_val_q.delete(); err_kind_q.delete(); err_t_q.delete();
  endfunction

  function automatic void model_err(input int kind, input int t);
    err_kind_q.push_back(kind);
    err_t_q.push_back(t);
  endfunction

  function automatic void model_byte(input logic [7:0] b, input logic stop_ok, input int t);
    logic [7:0] cmd, hi, lo;
    if (!stop_ok) begin
      model_err(1, t);
      fb.delete();
      return;
    end
    exp_q.push_back(b);
    exp_t_q.push_back(t);
    if (fb.size() == 0) begin
      if (b == 8'hA5) fb.push_back(b);
      return;
    end
    fb.push_back(b);
    if (fb.size() == 2 && (b < 8'd1 || b > 8'd4)) begin
      model_err(0, t);
      fb.delete();
    end else if (fb.size() == 5) begin
      cmd = fb[1]; hi = fb[2]; lo = fb[3];
      if ((cmd ^ hi ^ lo) != b) model_err(0, t);
      else if (cmd == 8'd4 && {hi, lo} > 16'd127) model_err(0, t);
      else begin
        upd_sel_q.push_back(2'(cmd - 8'd1));
        upd_val_q.push_back(cmd == 8'd4 ? {8'd0, lo & 8'h7F} : {hi, lo});
      end
      fb.delete();
    end
  endfunction

  // compare process
  always @(negedge clk) begin
    logic [7:0] b;
    logic [1:0] s;
    logic [15:0] v;
    int t, k;
    if (!reset) begin
      if (bump_next) begin
        if (m_err_cnt < 255) m_err_cnt++;
        bump_next = 1'b0;
      end
      if (rx_byte_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)", rx_byte, cyc);
        end else begin
          b = exp_q.pop_front();
          t = exp_t_q.pop_front();
          check("rx_byte", rx_byte, b);
          check_range("byte_latency", cyc - t, 78, 80);
        end
        last_valid_cyc = cyc;
      end
      if (param_valid) begin
        if (upd_sel_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_update: got sel %0d expected none (cycle %0d)", param_sel, cyc);
        end else begin
          s = upd_sel_q.pop_front();
          v = upd_val_q.pop_front();
          check("update_latency", cyc, last_valid_cyc + 1);
          m_sel = s;
          case (s)
            2'd0: m_kp = v;
            2'd1: m_ki = v;
            2'd2: m_kd = v;
            default: m_sp = v[6:0];
          endcase
        end
      end
      if (err_pulse) begin
        if (err_kind_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_err: got err_pulse expected none (cycle %0d)", cyc);
        end else begin
          k = err_kind_q.pop_front();
          t = err_t_q.pop_front();
          if (k == 0) check("parse_err_latency", cyc, last_valid_cyc + 1);
          else if (k == 1) check_range("frame_err_latency", cyc - t, 78, 80);
          else check_range("timeout_latency", cyc - last_valid_cyc, LIMIT, LIMIT + 2);
        end
        bump_next = 1'b1;
      end
      check("k_p", k_p, m_kp);
      check("k_i", k_i, m_ki);
      check("k_d", k_d, m_kd);
      check("setpoint", setpoint, m_sp);
      check("param_sel", param_sel, m_sel);
      check("err_count", err_count, m_err_cnt);
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bits(input logic [7:0] b, input logic stop);
    serial_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    serial_rx = stop;
    repeat (CPB) @(negedge clk);
    serial_rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    model_byte(b, stop, cyc);
    drive_bits(b, stop);
  endtask

  task automatic send5(input logic [7:0] b0, b1, b2, b3, b4, input int n);
    logic [7:0] v[5];
    v[0] = b0; v[1] = b1; v[2] = b2; v[3] = b3; v[4] = b4;
    for (int i = 0; i < n; i++) send_byte(v[i], 1'b1);
  endtask

  // start a byte but do something disruptive after three data bits
  task automatic partial_byte(input logic [7:0] b, input bit use_reset);
    @(negedge clk);
    serial_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        if (use_reset) begin
          reset = 1'b1;
          model_reset();
          #1;
          check("rst_mid_k_p", k_p, 500);
          check("rst_mid_k_i", k_i, 0);
          check("rst_mid_setpoint", setpoint, 30);
          check("rst_mid_err_count", err_count, 0);
          check("rst_mid_rx_byte", rx_byte, 0);
          check("rst_mid_param_valid", param_valid, 0);
        end else en = 1'b0;
      end
      serial_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    serial_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    model_reset();
    idle(5);
    check("reset_k_p", k_p, 500);
    check("reset_err_count", err_count, 0);
    reset = 1'b0;
    idle(2);
    check("init_k_p", k_p, 500);
    check("init_k_i", k_i, 0);
    check("init_k_d", k_d, 0);
    check("init_setpoint", setpoint, 30);
    check("init_param_sel", param_sel, 0);
    check("init_rx_byte", rx_byte, 0);
    check("init_pulses", {param_valid, rx_byte_valid, err_pulse}, 0);
    idle(20 * 10 * CPB);

    // gain writes
    send5(8'hA5, 8'h01, 8'h03, 8'hE8, 8'hEA, 5);
    idle(4);
    check("kp_1000", k_p, 1000);
    check("sel_kp", param_sel, 0);
    send5(8'hA5, 8'h03, 8'h00, 8'h0A, 8'h09, 5);
    idle(4);
    check("kd_10", k_d, 10);
    check("sel_kd", param_sel, 2);

    // bad checksum, bad command, then a good k_i write
    send5(8'hA5, 8'h03, 8'h00, 8'h10, 8'h00, 5);
    idle(4);
    check("kd_kept", k_d, 10);
    check("errcnt_1", err_count, 1);
    send5(8'hA5, 8'h07, 8'h00, 8'h00, 8'h00, 2);
    idle(4);
    check("errcnt_2", err_count, 2);
    send5(8'hA5, 8'h02, 8'h00, 8'h05, 8'h07, 5);
    idle(4);
    check("ki_5", k_i, 5);

    // setpoint range
    send5(8'hA5, 8'h04, 8'h00, 8'h80, 8'h84, 5);
    idle(4);
    check("errcnt_3", err_count, 3);
    check("sp_kept", setpoint, 30);
    send5(8'hA5, 8'h04, 8'h00, 8'h28, 8'h2C, 5);
    idle(4);
    check("sp_40", setpoint, 40);
    check("sel_sp", param_sel, 3);

    // framing error on HI, then a good frame; then a short glitch
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b0);
    idle(20);
    check("errcnt_4", err_count, 4);
    send5(8'hA5, 8'h02, 8'h00, 8'h09, 8'h0B, 5);
    idle(4);
    check("ki_9", k_i, 9);
    @(negedge clk);
    serial_rx = 1'b0;
    idle(CPB / 4);
    serial_rx = 1'b1;
    idle(20 * CPB);
    check("glitch_errcnt", err_count, 4);

    // timeout after a partial frame
    send5(8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 2);
    model_err(2, 0);
    fb.delete();
    idle(LIMIT + 10);
    check("errcnt_5", err_count, 5);

    // en dropped mid-frame
    send5(8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 3);
    partial_byte(8'h07, 1'b0);
    fb.delete();
    idle(40);
    en = 1'b1;
    idle(LIMIT + 40);
    check("en_kp_kept", k_p, 1000);
    check("en_errcnt", err_count, 5);

    // reset during the LO byte
    send5(8'hA5, 8'h01, 8'h12, 8'h00, 8'h00, 3);
    partial_byte(8'h34, 1'b1);
    idle(10);
    reset = 1'b0;
    idle(LIMIT + 20);
    check("post_rst_k_p", k_p, 500);
    check("post_rst_k_d", k_d, 0);
    check("post_rst_sel", param_sel, 0);

    // saturation of the error counter
    for (int i = 0; i < 260; i++) send5(8'hA5, 8'h07, 8'h00, 8'h00, 8'h00, 2);
    idle(4);
    check("errcnt_sat", err_count, 255);
    send5(8'hA5, 8'h01, 8'h00, 8'h64, 8'h65, 5);
    idle(4);
    check("kp_100", k_p, 100);
    check("errcnt_still_sat", err_count, 255);

    idle(20);
    check("pending_bytes", exp_q.size(), 0);
    check("pending_updates", upd_sel_q.size(), 0);
    check("pending_errors", err_kind_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
